dma_stream_realign: RTL and testbench

//   Parametrised byte realigner between the DMA AXI data path and the user stream. Moves a
//   LEN-byte stream whose first byte sits at lane src_off of input word 0 so that it lands at

---
 rtl/dma_stream_realign.sv | 168 ++++++++++++++++
 tb/tb_dma_stream_realign.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_stream_realign.sv
// -----------------------------------------------------------------------------
// dma_stream_realign
//   Byte realigner between the DMA AXI data path and a user stream. A transfer
//   of `length` bytes whose first byte sits at lane src_off of input word 0 is
//   re-emitted so that its first byte lands at lane dst_off of output word 0.
//   Unused output lanes are driven to zero and flagged off in out_strb; the
//   final beat carries out_last.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   start                    sample src_off/dst_off/length when ready=1
//   src_off, dst_off         first-byte lane in input / output word 0
//   length                   transfer size in bytes (0 = no-op)
//   ready                    idle, start is accepted
//   in_data/in_valid/in_ready             input word stream
//   out_data/out_strb/out_valid/out_last/out_ready   realigned output stream
// -----------------------------------------------------------------------------
module dma_stream_realign #(
    parameter  int DATA_W = 32,
    parameter  int LEN_W  = 16,
    localparam int NB     = DATA_W / 8,
    localparam int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OFF_W-1:0]  src_off,
    input  logic [OFF_W-1:0]  dst_off,
    input  logic [LEN_W-1:0]  length,
    output logic              ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [NB-1:0]     out_strb,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready
);
    localparam int CW = LEN_W + 1;
    localparam int PW = CW + OFF_W + 2;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t state, state_nxt;

    logic [OFF_W-1:0]    src_q, dst_q;
    logic [LEN_W-1:0]    len_q;
    logic                lag_q;
    logic [CW-1:0]       in_words, out_words, in_cnt, out_cnt;
    logic [DATA_W-1:0]   residue;

    logic [CW:0]         in_sum, out_sum;
    logic [CW-1:0]       in_words_calc, out_words_calc;
    logic                can_load, need_out, in_fire, flush_load, load, out_fire, cfg_take;
    logic [OFF_W-1:0]    rot;
    logic [OFF_W:0]      shamt;
    logic [2*DATA_W-1:0] window, shifted;
    logic [NB-1:0]       strb_nxt;
    logic [DATA_W-1:0]   data_nxt;

    // Lane j of output word k carries stream byte k*NB+j-dst; it is live when
    // that index falls inside [0, length).
    function automatic logic lane_on(input logic [CW-1:0] k, input int j,
                                     input logic [OFF_W-1:0] d, input logic [LEN_W-1:0] n);
        logic signed [PW-1:0] pos, lim;
        pos = $signed({2'b00, k, {OFF_W{1'b0}}}) + PW'(j) - $signed(PW'(d));
        lim = $signed(PW'(n));
        return (pos >= 0) && (pos < lim);
    endfunction

    always_comb begin
        in_sum         = (CW+1)'(length) + (CW+1)'(src_off) + (CW+1)'(NB - 1);
        out_sum        = (CW+1)'(length) + (CW+1)'(dst_off) + (CW+1)'(NB - 1);
        in_words_calc  = CW'(in_sum >> OFF_W);
        out_words_calc = CW'(out_sum >> OFF_W);
    end

    // When dst_off < src_off, output word k straddles input words k and k+1,
    // so the first input word only primes the residue (lag of one word).
    // Otherwise output word k is built from input words k-1 (residue) and k.
    assign rot        = dst_q - src_q;
    assign shamt      = (OFF_W+1)'(NB) - {1'b0, rot};
    assign can_load   = !out_valid || out_ready;
    assign need_out   = (in_cnt >= CW'(lag_q)) && (out_cnt < out_words);
    assign ready      = (state == IDLE);
    assign in_ready   = (state == RUN) && (in_cnt < in_words) && (!need_out || can_load);
    assign in_fire    = in_valid && in_ready;
    assign flush_load = (state == FLUSH) && (out_cnt < out_words) && can_load;
    assign load       = (in_fire && need_out) || flush_load;
    assign out_fire   = out_valid && out_ready;
    assign cfg_take   = start && ready && (length != '0);

    // Window = {incoming word, previous word}; in FLUSH no new word exists.
    assign window  = {((state == FLUSH) ? {DATA_W{1'b0}} : in_data), residue};
    assign shifted = window >> {shamt, 3'b000};

    always_comb begin
        strb_nxt = '0;
        data_nxt = '0;
        for (int j = 0; j < NB; j++) begin
            strb_nxt[j]        = lane_on(out_cnt, j, dst_q, len_q);
            data_nxt[8*j +: 8] = strb_nxt[j] ? shifted[8*j +: 8] : 8'h00;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (cfg_take) state_nxt = RUN;
            RUN: begin
                if (out_fire && out_last)
                    state_nxt = IDLE;
                else if (in_fire && (in_cnt + CW'(1) == in_words) &&
                         ((out_cnt + CW'(load)) < out_words))
                    state_nxt = FLUSH;
            end
            FLUSH: if (out_fire && out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            lag_q     <= 1'b0;
            in_words  <= '0;
            out_words <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            residue   <= '0;
            out_data  <= '0;
            out_strb  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cfg_take) begin
                src_q     <= src_off;
                dst_q     <= dst_off;
                len_q     <= length;
                lag_q     <= (dst_off < src_off);
                in_words  <= in_words_calc;
                out_words <= out_words_calc;
                in_cnt    <= '0;
                out_cnt   <= '0;
                residue   <= '0;
            end
            if (in_fire) begin
                in_cnt  <= in_cnt + CW'(1);
                residue <= in_data;
            end
            // Output holding stage: reload may coincide with the sink draining it.
            if (load) begin
                out_data  <= data_nxt;
                out_strb  <= strb_nxt;
                out_valid <= 1'b1;
                out_last  <= (out_cnt + CW'(1) == out_words);
                out_cnt   <= out_cnt + CW'(1);
            end else if (out_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dma_stream_realign.sv
module tb_dma_stream_realign;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, in_valid, out_ready, wide;
    logic [3:0]   src, dst;
    logic [15:0]  len;
    logic [127:0] in_data;

    logic        a_ready, a_in_ready, a_out_valid, a_out_last;
    logic [31:0] a_out_data;
    logic [3:0]  a_out_strb;
    logic        b_ready, b_in_ready, b_out_valid, b_out_last;
    logic [63:0] b_out_data;
    logic [7:0]  b_out_strb;

    dma_stream_realign #(.DATA_W(32), .LEN_W(16)) u_a (
        .clk(clk), .rst(rst), .start(start && !wide), .src_off(src[1:0]), .dst_off(dst[1:0]),
        .length(len), .ready(a_ready), .in_data(in_data[31:0]), .in_valid(in_valid && !wide),
        .in_ready(a_in_ready), .out_data(a_out_data), .out_strb(a_out_strb),
        .out_valid(a_out_valid), .out_last(a_out_last), .out_ready(out_ready)
    );

    dma_stream_realign #(.DATA_W(64), .LEN_W(16)) u_b (
        .clk(clk), .rst(rst), .start(start && wide), .src_off(src[2:0]), .dst_off(dst[2:0]),
        .length(len), .ready(b_ready), .in_data(in_data[63:0]), .in_valid(in_valid && wide),
        .in_ready(b_in_ready), .out_data(b_out_data), .out_strb(b_out_strb),
        .out_valid(b_out_valid), .out_last(b_out_last), .out_ready(out_ready)
    );

    logic         c_ready, c_in_ready, c_out_valid, c_out_last;
    logic [127:0] c_out_data;
    logic [15:0]  c_out_strb;
    assign c_ready     = wide ? b_ready     : a_ready;
    assign c_in_ready  = wide ? b_in_ready  : a_in_ready;
    assign c_out_valid = wide ? b_out_valid : a_out_valid;
    assign c_out_last  = wide ? b_out_last  : a_out_last;
    assign c_out_data  = wide ? {64'b0, b_out_data} : {96'b0, a_out_data};
    assign c_out_strb  = wide ? {8'b0, b_out_strb}  : {12'b0, a_out_strb};

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]   stream_q[$];
    logic [127:0] word_q[$];
    logic [127:0] exp_d[$];
    logic [15:0]  exp_s[$];
    logic         exp_l[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_stream(input int n, input int base, input bit rnd);
        stream_q.delete();
        for (int i = 0; i < n; i++)
            stream_q.push_back(rnd ? 8'($urandom) : 8'(base + i));
    endtask

    // Reference: stream byte i sits at input global lane i+s and output global lane i+d.
    task automatic build(input int nb, input int s, input int d, input int n);
        int in_w, out_w, i;
        logic [127:0] wd, ed;
        logic [15:0]  es;
        in_w  = (s + n + nb - 1) / nb;
        out_w = (d + n + nb - 1) / nb;
        word_q.delete(); exp_d.delete(); exp_s.delete(); exp_l.delete();
        for (int w = 0; w < in_w; w++) begin
            wd = '0;
            for (int lane = 0; lane < nb; lane++) begin
                i = w * nb + lane - s;
                wd[lane*8 +: 8] = (i >= 0 && i < n) ? stream_q[i] : 8'($urandom);
            end
            word_q.push_back(wd);
        end
        for (int k = 0; k < out_w; k++) begin
            ed = '0;
            es = '0;
            for (int j = 0; j < nb; j++) begin
                i = k * nb + j - d;
                if (i >= 0 && i < n) begin
                    ed[j*8 +: 8] = stream_q[i];
                    es[j] = 1'b1;
                end
            end
            exp_d.push_back(ed);
            exp_s.push_back(es);
            exp_l.push_back(k == out_w - 1);
        end
    endtask

    task automatic set_exp(input logic [127:0] d0, input logic [15:0] s0, input logic l0);
        exp_d.push_back(d0);
        exp_s.push_back(s0);
        exp_l.push_back(l0);
    endtask

    task automatic do_start(input int s, input int d, input int n);
        @(negedge clk);
        src = 4'(s); dst = 4'(d); len = 16'(n);
        in_valid = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic xfer(input int nb, input int s, input int d, input int n,
                        input bit rnd, input bit poke);
        int in_w, out_w, wi, got, cyc;
        logic [127:0] ed;
        logic [15:0]  es;
        logic         el;
        in_w  = (s + n + nb - 1) / nb;
        out_w = (d + n + nb - 1) / nb;
        do_start(s, d, n);
        wi = 0; got = 0; cyc = 0;
        while ((wi < in_w || got < out_w) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            in_valid  = (wi < in_w) && (!rnd || $urandom_range(0, 1) == 1);
            in_data   = (wi < in_w) ? word_q[wi] : {$urandom, $urandom, $urandom, $urandom};
            out_ready = !rnd || $urandom_range(0, 1) == 1;
            if (poke && cyc == 2) begin
                start = 1'b1; src = 4'd0; dst = 4'd0; len = 16'd3;
            end else begin
                start = 1'b0;
            end
            #1;
            if (in_valid && c_in_ready) wi++;
            if (c_out_valid && out_ready) begin
                if (exp_d.size() == 0) begin
                    chk("beat_excess", {127'b0, c_out_valid}, 128'd0);
                end else begin
                    ed = exp_d.pop_front();
                    es = exp_s.pop_front();
                    el = exp_l.pop_front();
                    chk("out_data", c_out_data, ed);
                    chk("out_strb", 128'(c_out_strb), 128'(es));
                    chk("out_last", 128'(c_out_last), 128'(el));
                end
                got++;
            end
        end
        start = 1'b0;
        chk("in_words", 128'(wi), 128'(in_w));
        chk("out_beats", 128'(got), 128'(out_w));
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("ready_after", 128'(c_ready), 128'd1);
        chk("in_ready_after", 128'(c_in_ready), 128'd0);
        chk("out_valid_after", 128'(c_out_valid), 128'd0);
        in_valid = 1'b0;
    endtask

    initial begin
        int wi;
        bit seen;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; wide = 1'b0;
        src = '0; dst = '0; len = '0; in_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready",     128'(a_ready),     128'd1);
        chk("rst_in_ready",  128'(a_in_ready),  128'd0);
        chk("rst_out_valid", 128'(a_out_valid), 128'd0);
        chk("rst_out_last",  128'(a_out_last),  128'd0);
        chk("rst_out_strb",  128'(a_out_strb),  128'd0);
        chk("rst_out_data",  128'(a_out_data),  128'd0);
        chk("rst_ready_w",   128'(b_ready),     128'd1);
        rst = 1'b0;

        // read-side style shift right: dst > src
        fill_stream(6, 'h10, 1'b0);
        build(4, 0, 3, 6);
        exp_d.delete(); exp_s.delete(); exp_l.delete();
        set_exp(128'h10000000, 16'h8, 1'b0);
        set_exp(128'h14131211, 16'hF, 1'b0);
        set_exp(128'h00000015, 16'h1, 1'b1);
        xfer(4, 0, 3, 6, 1'b0, 1'b0);

        // dst < src: needs word 1 before first beat, exactly two words taken
        fill_stream(5, 'h10, 1'b0);
        build(4, 3, 0, 5);
        exp_d.delete(); exp_s.delete(); exp_l.delete();
        set_exp(128'h13121110, 16'hF, 1'b0);
        set_exp(128'h00000014, 16'h1, 1'b1);
        xfer(4, 3, 0, 5, 1'b0, 1'b0);

        // zero-length start is a no-op
        do_start(2, 1, 0);
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("len0_ready",     128'(a_ready),     128'd1);
        chk("len0_in_ready",  128'(a_in_ready),  128'd0);
        chk("len0_out_valid", 128'(a_out_valid), 128'd0);
        in_valid = 1'b0;

        // start while busy must not disturb the transfer in flight
        fill_stream(9, 'h40, 1'b1);
        build(4, 1, 2, 9);
        xfer(4, 1, 2, 9, 1'b0, 1'b1);

        // 64-bit bus: 3 input words, 2 output beats
        wide = 1'b1;
        fill_stream(13, 'h20, 1'b0);
        build(8, 5, 2, 13);
        exp_d.delete(); exp_s.delete(); exp_l.delete();
        set_exp(128'h2524232221200000, 16'hFC, 1'b0);
        set_exp(128'h002C2B2A29282726, 16'h7F, 1'b1);
        xfer(8, 5, 2, 13, 1'b0, 1'b0);
        wide = 1'b0;

        // long random-backpressure transfers across every offset pair
        for (int s = 0; s < 4; s++) begin
            for (int d = 0; d < 4; d++) begin
                fill_stream(1024, 0, 1'b1);
                build(4, s, d, 1024);
                xfer(4, s, d, 1024, 1'b1, 1'b0);
            end
        end

        // reset while a beat is stalled on the output
        fill_stream(12, 'h60, 1'b0);
        build(4, 1, 0, 12);
        do_start(1, 0, 12);
        wi = 0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = word_q[wi];
            out_ready = 1'b0;
            #1;
            if (in_valid && a_in_ready) wi++;
            if (a_out_valid) seen = 1'b1;
        end
        chk("rst_setup_valid", 128'(a_out_valid), 128'd1);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("mid_rst_ready",     128'(a_ready),     128'd1);
        chk("mid_rst_in_ready",  128'(a_in_ready),  128'd0);
        chk("mid_rst_out_valid", 128'(a_out_valid), 128'd0);
        chk("mid_rst_out_last",  128'(a_out_last),  128'd0);
        chk("mid_rst_out_strb",  128'(a_out_strb),  128'd0);
        chk("mid_rst_out_data",  128'(a_out_data),  128'd0);
        @(negedge clk);
        rst = 1'b0;
        fill_stream(11, 'h70, 1'b1);
        build(4, 2, 3, 11);
        xfer(4, 2, 3, 11, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
